// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 mux arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity, used for the round-robin pointer
//   SEL_IN1/2   : encodings of the shared mux select
//   CNT_W       : width of the per-grant beat counter
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_ID_1 = 2'd1,
        REQ_ID_2 = 2'd2
    } req_id_t;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mux_arb_out_reg.sv
// One-entry valid/ready output register holding {data, last}.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   load                  : capture load_data/load_last this cycle
//   load_data, load_last  : beat to capture
//   can_load              : register is empty or draining this cycle
//   out_valid/data/last   : registered beat
//   out_ready             : downstream accepts the beat
module mux_arb_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             can_load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Accepting while the current beat drains keeps one beat per cycle.
    assign can_load = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/mux_2_1_arbiter.sv
// Round-robin arbiter/sequencer sharing one 2:1 datapath between two
// valid/ready requesters. Grants are held for a burst (until last, or
// until MAX_BEATS beats while the other side waits).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   inX_data/valid/last, inX_ready  : requester X (X = 1, 2)
//   out_data/valid/last, out_ready  : registered output beat
//   sel                             : shared mux select, 0 = in1, 1 = in2
//
// state  | meaning
// IDLE   | no grant; both readies low, sel holds
// GRANT1 | in1 owns the datapath, sel = 0
// GRANT2 | in2 owns the datapath, sel = 1
module mux_2_1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    input  logic             in2_last,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel
);

    localparam logic [CNT_W-1:0] MAX_BEATS_C = CNT_W'(MAX_BEATS);

    arb_state_t       state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sel_q, sel_d;

    logic             can_load;
    logic             acc1, acc2, load;
    logic [WIDTH-1:0] load_data;
    logic             load_last;
    logic             own_valid, other_valid;
    logic [CNT_W-1:0] count_inc;
    logic             release_grant;

    assign in1_ready = (state_q == GRANT1) && can_load;
    assign in2_ready = (state_q == GRANT2) && can_load;

    assign acc1      = in1_valid && in1_ready;
    assign acc2      = in2_valid && in2_ready;
    assign load      = acc1 || acc2;
    assign load_data = acc2 ? in2_data : in1_data;
    assign load_last = acc2 ? in2_last : in1_last;

    assign own_valid   = (state_q == GRANT2) ? in2_valid : in1_valid;
    assign other_valid = (state_q == GRANT2) ? in1_valid : in2_valid;
    assign count_inc   = count_q + CNT_W'(1);

    // The beat limit only forces a handover when the other side is waiting.
    assign release_grant = load_last || ((count_inc == MAX_BEATS_C) && other_valid);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        sel_d        = sel_q;
        unique case (state_q)
            IDLE: begin
                if (in1_valid && (!in2_valid || last_grant_q == REQ_ID_2)) begin
                    state_d = GRANT1;
                    sel_d   = SEL_IN1;
                    count_d = '0;
                end else if (in2_valid) begin
                    state_d = GRANT2;
                    sel_d   = SEL_IN2;
                    count_d = '0;
                end
            end
            GRANT1, GRANT2: begin
                if (load) begin
                    if (release_grant) begin
                        last_grant_d = (state_q == GRANT2) ? REQ_ID_2 : REQ_ID_1;
                        count_d      = '0;
                        if (other_valid) begin
                            state_d = (state_q == GRANT2) ? GRANT1 : GRANT2;
                            sel_d   = (state_q == GRANT2) ? SEL_IN1 : SEL_IN2;
                        end else if (own_valid) begin
                            state_d = state_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        count_d = count_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_ID_2;
            count_q      <= '0;
            sel_q        <= SEL_IN1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            sel_q        <= sel_d;
        end
    end

    assign sel = sel_q;

    mux_arb_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Directed bench for mux_2_1_arbiter with an expected-order scoreboard.
module tb_mux_2_1_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in1_data, in2_data, out_data;
    logic        in1_valid, in1_last, in1_ready;
    logic        in2_valid, in2_last, in2_ready;
    logic        out_valid, out_last, out_ready, sel;

    always #5 clk = ~clk;

    mux_2_1_arbiter #(
        .WIDTH     (16),
        .MAX_BEATS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .in2_data  (in2_data),
        .in2_valid (in2_valid),
        .in2_last  (in2_last),
        .in2_ready (in2_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [16:0] src1[$], src2[$], exp_out[$];
    logic        exp_acc[$];
    bit          en1, en2, acc1_s, acc2_s, stall_prev;
    int          cyc, first_out, last_out, stall_lo, stall_hi, n_stall;
    logic [16:0] prev_beat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        in1_valid = en1 && (src1.size() > 0);
        in1_data  = '0;
        in1_last  = 1'b0;
        if (in1_valid) begin
            in1_data = src1[0][15:0];
            in1_last = src1[0][16];
        end
        in2_valid = en2 && (src2.size() > 0);
        in2_data  = '0;
        in2_last  = 1'b0;
        if (in2_valid) begin
            in2_data = src2[0][15:0];
            in2_last = src2[0][16];
        end
        out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic monitor();
        logic        e;
        logic [16:0] x;
        acc1_s = in1_valid && in1_ready;
        acc2_s = in2_valid && in2_ready;
        if (acc1_s || acc2_s) begin
            check("accept_expected", exp_acc.size() > 0, 1);
            if (exp_acc.size() > 0) begin
                e = exp_acc.pop_front();
                check("accept_src", {acc2_s, acc1_s}, e ? 2'b10 : 2'b01);
                check("sel_at_accept", sel, e);
            end
        end
        if (out_valid && out_ready) begin
            check("out_expected", exp_out.size() > 0, 1);
            if (exp_out.size() > 0) begin
                x = exp_out.pop_front();
                check("out_beat", {out_last, out_data}, x);
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (out_valid && !out_ready) begin
            n_stall++;
            check("bp_in1_ready", in1_ready, 0);
            check("bp_in2_ready", in2_ready, 0);
            if (stall_prev) check("bp_stable", {out_last, out_data}, prev_beat);
        end
        stall_prev = out_valid && !out_ready;
        prev_beat  = {out_last, out_data};
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (acc1_s) void'(src1.pop_front());
        if (acc2_s) void'(src2.pop_front());
        cyc++;
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_out.size() == 0 && exp_acc.size() == 0) break;
            step();
        end
        check("drain_out", exp_out.size(), 0);
        check("drain_acc", exp_acc.size(), 0);
    endtask

    task automatic clear_run();
        src1.delete();
        src2.delete();
        exp_out.delete();
        exp_acc.delete();
        cyc        = 0;
        first_out  = -1;
        last_out   = -1;
        n_stall    = 0;
        stall_prev = 1'b0;
        stall_lo   = 1000;
        stall_hi   = 1000;
        acc1_s     = 1'b0;
        acc2_s     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en1   = 1'b0;
        en2   = 1'b0;
        clear_run();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sel", sel, 0);
        check("rst_in1_ready", in1_ready, 0);
        check("rst_in2_ready", in2_ready, 0);

        // Single requester: 10, 20, 30(last)
        do_reset();
        en1 = 1'b1;
        src1.push_back({1'b0, 16'd10});
        src1.push_back({1'b0, 16'd20});
        src1.push_back({1'b1, 16'd30});
        repeat (3) exp_acc.push_back(1'b0);
        exp_out.push_back({1'b0, 16'd10});
        exp_out.push_back({1'b0, 16'd20});
        exp_out.push_back({1'b1, 16'd30});
        run(30);
        check("single_first_cycle", first_out, 2);
        check("single_last_cycle", last_out, 4);

        // Tie after reset, single-beat bursts: 10,1,10,1
        do_reset();
        en1 = 1'b1;
        en2 = 1'b1;
        repeat (2) src1.push_back({1'b1, 16'd10});
        repeat (2) src2.push_back({1'b1, 16'd1});
        for (int i = 0; i < 2; i++) begin
            exp_acc.push_back(1'b0);
            exp_acc.push_back(1'b1);
            exp_out.push_back({1'b1, 16'd10});
            exp_out.push_back({1'b1, 16'd1});
        end
        run(30);
        check("tie_first_cycle", first_out, 2);
        check("tie_no_bubbles", last_out - first_out, 3);

        // Burst limit (MAX_BEATS=4): in1 101..108 no last, in2 231 waiting
        do_reset();
        en1 = 1'b1;
        en2 = 1'b1;
        for (int i = 1; i <= 8; i++) src1.push_back({1'b0, 16'(100 + i)});
        src2.push_back({1'b1, 16'd231});
        for (int i = 1; i <= 4; i++) begin
            exp_acc.push_back(1'b0);
            exp_out.push_back({1'b0, 16'(100 + i)});
        end
        exp_acc.push_back(1'b1);
        exp_out.push_back({1'b1, 16'd231});
        for (int i = 5; i <= 8; i++) begin
            exp_acc.push_back(1'b0);
            exp_out.push_back({1'b0, 16'(100 + i)});
        end
        run(40);
        check("limit_no_bubbles", last_out - first_out, 8);

        // Backpressure: out_ready low for cycles 4..6
        do_reset();
        en1      = 1'b1;
        stall_lo = 4;
        stall_hi = 6;
        for (int i = 0; i < 5; i++) begin
            src1.push_back({(i == 4), 16'(50 + i)});
            exp_acc.push_back(1'b0);
            exp_out.push_back({(i == 4), 16'(50 + i)});
        end
        run(40);
        check("bp_stall_cycles", n_stall, 3);
        check("bp_last_cycle", last_out, 9);

        // Reset mid-burst: in1 single beat, then in2 streaming, then reset
        do_reset();
        en1 = 1'b1;
        en2 = 1'b1;
        src1.push_back({1'b1, 16'd60});
        for (int i = 0; i < 8; i++) src2.push_back({1'b0, 16'(200 + i)});
        exp_acc.push_back(1'b0);
        exp_acc.push_back(1'b1);
        exp_acc.push_back(1'b1);
        exp_out.push_back({1'b1, 16'd60});
        exp_out.push_back({1'b0, 16'd200});
        run(30);
        check("mid_sel_before_rst", sel, 1);
        drive();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_idle_rdy", {in2_ready, in1_ready}, 2'b00);
        clear_run();
        src1.push_back({1'b1, 16'd77});
        src2.push_back({1'b1, 16'd88});
        exp_acc.push_back(1'b0);
        exp_acc.push_back(1'b1);
        exp_out.push_back({1'b1, 16'd77});
        exp_out.push_back({1'b1, 16'd88});
        run(30);
        check("mid_tie_first_cycle", first_out, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
